// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared constants and types for the APU responder: opcodes, flag bit positions,
// FSM state encoding and the single restoring-division step.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_RESP_OP_ADD  = 0;
  localparam int unsigned APU_RESP_OP_SUB  = 1;
  localparam int unsigned APU_RESP_OP_MAC  = 2;
  localparam int unsigned APU_RESP_OP_DIVU = 3;
  localparam int unsigned APU_RESP_OP_REMU = 4;

  localparam int unsigned APU_FLAG_DZ  = 0;
  localparam int unsigned APU_FLAG_ILL = 1;
  localparam int unsigned APU_FLAG_OVF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } apu_resp_state_e;

  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] quo;
  } div_pair_t;

  // One radix-2 restoring step: the dividend shifts out of quo's MSB while the
  // new quotient bit shifts into its LSB.
  function automatic div_pair_t div_step(input logic [31:0] rem,
                                         input logic [31:0] quo,
                                         input logic [31:0] div);
    logic [32:0] partial;
    logic [32:0] diff;
    div_pair_t   res;
    partial = {rem, quo[31]};
    diff    = partial - {1'b0, div};
    if (!diff[32]) begin
      res.rem = diff[31:0];
      res.quo = {quo[30:0], 1'b1};
    end else begin
      res.rem = partial[31:0];
      res.quo = {quo[30:0], 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_responder_if.sv
// Request/response bus between the core (master) and the APU responder (slave).
interface cv32e40p_apu_responder_if #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NUSFLAGS_CPU = 5
);

  logic                                apu_req_i;
  logic                                apu_gnt_o;
  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i;
  logic [APU_WOP_CPU-1:0]              apu_op_i;
  logic                                apu_rvalid_o;
  logic [31:0]                         apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_o;
  logic                                apu_busy_o;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, apu_busy_o
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, apu_busy_o
  );

endinterface

// File: rtl/cv32e40p_apu_resp_div.sv
// Serial unsigned divider: the first quotient bit is resolved on the start edge,
// the remaining 31 on the following edges; done pulses once the result is final.
module cv32e40p_apu_resp_div
  import cv32e40p_apu_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic [4:0]  cnt_q;
  logic        active_q;
  logic        done_q;
  div_pair_t   first_step;
  div_pair_t   next_step;

  assign first_step = div_step(32'd0, a, b);
  assign next_step  = div_step(rem_q, quo_q, div_q);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q    <= first_step.rem;
        quo_q    <= first_step.quo;
        div_q    <= b;
        cnt_q    <= 5'd31;
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= next_step.rem;
        quo_q <= next_step.quo;
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/cv32e40p_apu_responder.sv
// APU responder: accepts one ADD/SUB/MAC/DIVU/REMU request at a time from the
// core and returns a registered single-cycle result pulse.
module cv32e40p_apu_responder
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input logic                      clk,
  input logic                      rst,
  cv32e40p_apu_responder_if.slave  bus
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(APU_RESP_OP_ADD);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(APU_RESP_OP_SUB);
  localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(APU_RESP_OP_MAC);
  localparam logic [APU_WOP_CPU-1:0] OP_DIVU = APU_WOP_CPU'(APU_RESP_OP_DIVU);
  localparam logic [APU_WOP_CPU-1:0] OP_REMU = APU_WOP_CPU'(APU_RESP_OP_REMU);

  apu_resp_state_e              state_q;
  logic [APU_WOP_CPU-1:0]       op_q;
  logic [31:0]                  a_q;
  logic [31:0]                  b_q;
  logic [31:0]                  c_q;
  logic [31:0]                  prod_q;
  logic                         mac_phase_q;
  logic                         rvalid_q;
  logic [31:0]                  result_q;
  logic [APU_NUSFLAGS_CPU-1:0]  flags_q;

  logic                         gnt;
  logic                         in_is_div;
  logic                         div_start;
  logic                         op_is_mac;
  logic                         op_is_long_div;
  logic [31:0]                  div_quotient;
  logic [31:0]                  div_remainder;
  logic                         div_done;
  logic [31:0]                  sum;
  logic [31:0]                  diff;
  logic [31:0]                  calc_result;
  logic [APU_NUSFLAGS_CPU-1:0]  calc_flags;

  assign gnt = bus.apu_req_i & (state_q == ST_IDLE) & ~rst;

  // The divider is launched on the accept edge straight from the bus so that
  // its 32 steps line up exactly with the CALC cycles.
  assign in_is_div = (bus.apu_op_i == OP_DIVU) | (bus.apu_op_i == OP_REMU);
  assign div_start = gnt & in_is_div & (bus.apu_operands_i[1] != 32'd0);

  assign op_is_mac      = (op_q == OP_MAC);
  assign op_is_long_div = ((op_q == OP_DIVU) | (op_q == OP_REMU)) & (b_q != 32'd0);

  cv32e40p_apu_resp_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (bus.apu_operands_i[0]),
    .b         (bus.apu_operands_i[1]),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .done      (div_done)
  );

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    calc_result = 32'd0;
    calc_flags  = '0;
    unique case (op_q)
      OP_ADD: begin
        calc_result              = sum;
        calc_flags[APU_FLAG_OVF] = (a_q[31] == b_q[31]) & (sum[31] != a_q[31]);
      end
      OP_SUB: begin
        calc_result              = diff;
        calc_flags[APU_FLAG_OVF] = (a_q[31] != b_q[31]) & (diff[31] != a_q[31]);
      end
      OP_MAC: calc_result = prod_q + c_q;
      OP_DIVU: begin
        calc_result             = (b_q == 32'd0) ? 32'hFFFF_FFFF : div_quotient;
        calc_flags[APU_FLAG_DZ] = (b_q == 32'd0);
      end
      OP_REMU: begin
        calc_result             = (b_q == 32'd0) ? a_q : div_remainder;
        calc_flags[APU_FLAG_DZ] = (b_q == 32'd0);
      end
      default: calc_flags[APU_FLAG_ILL] = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      prod_q      <= '0;
      mac_phase_q <= 1'b0;
      rvalid_q    <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt) begin
            op_q        <= bus.apu_op_i;
            a_q         <= bus.apu_operands_i[0];
            b_q         <= bus.apu_operands_i[1];
            c_q         <= bus.apu_operands_i[2];
            mac_phase_q <= 1'b0;
            state_q     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (op_is_mac && !mac_phase_q) begin
            prod_q      <= a_q * b_q;
            mac_phase_q <= 1'b1;
          end else if (!op_is_long_div || div_done) begin
            result_q <= calc_result;
            flags_q  <= calc_flags;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.apu_gnt_o    = gnt;
  assign bus.apu_rvalid_o = rvalid_q;
  assign bus.apu_result_o = result_q;
  assign bus.apu_flags_o  = flags_q;
  assign bus.apu_busy_o   = (state_q != ST_IDLE);

endmodule

// File: doc/cv32e40p_apu_responder.md
CV32E40P_APU_RESPONDER -- requirements
Module: cv32e40p_apu_responder

Interface
REQ-001 SHALL have parameter APU_NARGS_CPU, default 3: number of 32-bit operands per request.
REQ-002 SHALL have parameter APU_WOP_CPU, default 6: opcode width.
REQ-003 SHALL have parameter APU_NUSFLAGS_CPU, default 5: response flag width.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port apu_req_i, input, 1: request valid from the core.
REQ-007 SHALL have port apu_gnt_o, output, 1: request accepted.
REQ-008 SHALL have port apu_operands_i, input, APU_NARGS_CPU x 32: operands a, b, c (index 0, 1, 2).
REQ-009 SHALL have port apu_op_i, input, APU_WOP_CPU: opcode.
REQ-010 SHALL have port apu_rvalid_o, output, 1: one-cycle result pulse with no backpressure.
REQ-011 SHALL have port apu_result_o, output, 32: result.
REQ-012 SHALL have port apu_flags_o, output, APU_NUSFLAGS_CPU: {2'b0, ovf, illegal, dz}.
REQ-013 SHALL have port apu_busy_o, output, 1: operation in flight.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, CALC and RESP.
REQ-015 SHALL drive apu_gnt_o = apu_req_i & (state == IDLE) combinationally; the grant is never given in CALC or RESP.
REQ-016 SHALL, on req & gnt at cycle t, latch the operands and opcode and enter CALC at t+1.
REQ-017 SHALL support these opcodes:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 MAC: a*b+c, low 32 bits
  - 3 DIVU: a/b
  - 4 REMU: a%b
REQ-018 SHALL keep CALC for 1 cycle for ADD, SUB, illegal opcodes and divide-by-zero; 2 cycles for MAC; 32 cycles for DIVU/REMU with b != 0.
REQ-019 SHALL enter RESP after the last CALC cycle, giving these rvalid cycles:
  - ADD/SUB: t+2
  - MAC: t+3
  - DIVU/REMU: t+33
REQ-020 SHALL assert apu_rvalid_o only in RESP, for exactly one cycle, and then return to IDLE.
REQ-021 SHALL register apu_result_o and apu_flags_o, update them only on entry to RESP, and hold them stable otherwise.
REQ-022 SHALL wrap ADD/SUB modulo 2^32 and set ovf on signed overflow: operand signs equal (ADD) or different (SUB) and the result sign differs from operand a.
REQ-023 SHALL, for DIVU/REMU with b == 0, return 32'hFFFF_FFFF (DIVU) or a (REMU) and set dz.
REQ-024 SHALL, for opcodes 5..2^APU_WOP_CPU-1, return 0 with illegal set; the opcode is still granted and answered.
REQ-025 SHALL compute DIVU/REMU by restoring radix-2 division with one quotient bit per CALC cycle, MSB first.
REQ-026 SHALL drive apu_busy_o = (state != IDLE).
REQ-027 SHALL NOT grant a request presented in the RESP cycle; that request is granted in the next (IDLE) cycle if still held.
REQ-028 SHALL ignore operand and opcode changes while in CALC.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set:
  - state = IDLE
  - apu_rvalid_o = 0
  - apu_result_o = 0
  - apu_flags_o = 0
  - apu_busy_o = 0
  - divider state = 0
REQ-030 SHALL force apu_gnt_o = 0 while rst is high.
REQ-031 SHALL, when reset is asserted mid-CALC or in RESP, drop the in-flight operation with no rvalid pulse, including in the cycle after reset is released.

Structure
REQ-032 SHALL place opcode constants (APU_RESP_OP_ADD .. APU_RESP_OP_REMU) and flag bit indices (APU_FLAG_DZ=0, APU_FLAG_ILL=1, APU_FLAG_OVF=2) in cv32e40p_apu_core_pkg.
REQ-033 SHALL implement the serial divider as sub-module cv32e40p_apu_resp_div with:
  - start, a, b inputs
  - quotient, remainder, done outputs
  - its own 5-bit iteration counter
  - the same clk/rst.
REQ-034 SHALL keep the MAC product in a pipeline register between its two CALC cycles.

Verification
REQ-035 SHALL cover ADD: req with a=32'h7FFF_FFFF, b=1, op=0 at t -> gnt at t, rvalid at t+2, result 32'h8000_0000, flags 5'b00100.
REQ-036 SHALL cover MAC: a=3, b=5, c=7, op=2 -> rvalid at t+3, result 22, flags 0; req held during CALC/RESP -> gnt=0 until the following IDLE cycle.
REQ-037 SHALL cover division: DIVU a=100, b=7 -> rvalid at t+33, result 14; REMU a=100, b=7 -> rvalid at t+33, result 2.
REQ-038 SHALL cover divide-by-zero: DIVU a=5, b=0 -> rvalid at t+2, result 32'hFFFF_FFFF, flags 5'b00001; REMU a=5, b=0 -> result 5, dz set.
REQ-039 SHALL cover illegal opcode: op=6'd9 -> gnt at t, rvalid at t+2, result 0, flags 5'b00010.
REQ-040 SHALL cover reset during DIVU: rst high at CALC cycle 10 -> no rvalid at any later cycle, busy=0, result 0; a fresh ADD 1+2 afterwards -> result 3 at t+2.
